// File: rtl/axi_scratchpad_slave.sv
// AXI4 slave that serves one transaction at a time from an on-chip word scratchpad.
// Handshake rule on every channel: a beat transfers on a rising edge with valid && ready; valid never waits on ready.
module axi_scratchpad_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    ID_WIDTH   = 2,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [1:0]              dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WDATA = 2'd1, WRESP = 2'd2, RDATA = 2'd3} state_e;

    localparam int                  STRB_W     = DATA_WIDTH / 8;
    localparam int                  IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] WIN_BYTES  = (ADDR_WIDTH + 1)'(4 * DEPTH);
    localparam logic [1:0]          BURST_INCR = 2'b01;
    localparam logic [1:0]          RESP_OKAY  = 2'b00;
    localparam logic [1:0]          RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  wrap_q, wrap_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;

    logic                  grant_w, grant_r, aw_ready, ar_ready, mem_we;
    logic [ADDR_WIDTH-1:0] beat_addr, beat_off, next_addr;
    logic [1:0]            beat_burst;
    logic [2:0]            beat_size;
    logic                  beat_wrap, beat_ok, next_wrap;
    logic [ADDR_WIDTH:0]   beat_inc;
    logic [IDX_W-1:0]      beat_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // In IDLE the datapath looks at the incoming AR so beat 0 can be registered on the AR handshake;
    // otherwise addr_q holds the current write beat or the next read beat.
    assign beat_addr  = (state_q == IDLE) ? s_axi_araddr  : addr_q;
    assign beat_burst = (state_q == IDLE) ? s_axi_arburst : burst_q;
    assign beat_size  = (state_q == IDLE) ? s_axi_arsize  : size_q;
    assign beat_wrap  = (state_q == IDLE) ? 1'b0          : wrap_q;

    assign beat_off  = beat_addr - BASE_ADDR;
    assign beat_ok   = !beat_wrap && !beat_burst[1] && (beat_size <= 3'd2) && ({1'b0, beat_off} < WIN_BYTES);
    assign beat_idx  = beat_off[IDX_W+1:2];
    assign beat_inc  = {1'b0, beat_addr} + ((ADDR_WIDTH + 1)'(1) << beat_size);
    assign next_addr = (beat_burst == BURST_INCR) ? beat_inc[ADDR_WIDTH-1:0] : beat_addr;
    // A carry out of the top of the address space poisons the rest of the burst.
    assign next_wrap = beat_wrap | ((beat_burst == BURST_INCR) & beat_inc[ADDR_WIDTH]);
    assign rd_word   = beat_ok ? mem[beat_idx] : '0;

    assign grant_w = rst_ni && s_axi_awvalid && (!s_axi_arvalid || !rr_q);
    assign grant_r = rst_ni && s_axi_arvalid && (!s_axi_awvalid || rr_q);

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        wrap_d   = wrap_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        aw_ready = 1'b0;
        ar_ready = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_w) begin
                    aw_ready = 1'b1;
                    state_d  = WDATA;
                    rr_d     = ~rr_q;
                    id_d     = s_axi_awid;
                    addr_d   = s_axi_awaddr;
                    len_d    = s_axi_awlen;
                    size_d   = s_axi_awsize;
                    burst_d  = s_axi_awburst;
                    wrap_d   = 1'b0;
                    cnt_d    = 8'd0;
                    err_d    = 1'b0;
                end else if (grant_r) begin
                    ar_ready = 1'b1;
                    state_d  = RDATA;
                    rr_d     = ~rr_q;
                    id_d     = s_axi_arid;
                    addr_d   = next_addr;
                    len_d    = s_axi_arlen;
                    size_d   = s_axi_arsize;
                    burst_d  = s_axi_arburst;
                    wrap_d   = next_wrap;
                    cnt_d    = 8'd0;
                    rdata_d  = rd_word;
                    rresp_d  = beat_ok ? RESP_OKAY : RESP_SLVERR;
                    rlast_d  = (s_axi_arlen == 8'd0);
                end
            end
            WDATA: begin
                if (s_axi_wvalid) begin
                    mem_we = rst_ni && beat_ok;
                    addr_d = next_addr;
                    wrap_d = next_wrap;
                    cnt_d  = cnt_q + 8'd1;
                    if (!beat_ok || (s_axi_wlast != (cnt_q == len_q))) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == len_q) begin
                        state_d = WRESP;
                    end
                end
            end
            WRESP: begin
                if (s_axi_bready) begin
                    state_d = IDLE;
                end
            end
            RDATA: begin
                if (s_axi_rready) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        addr_d  = next_addr;
                        wrap_d  = next_wrap;
                        cnt_d   = cnt_q + 8'd1;
                        rdata_d = rd_word;
                        rresp_d = beat_ok ? RESP_OKAY : RESP_SLVERR;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rresp_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            rlast_q <= rlast_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[beat_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = aw_ready;
    assign s_axi_arready = ar_ready;
    assign s_axi_wready  = (state_q == WDATA);
    assign s_axi_bvalid  = (state_q == WRESP);
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = ((state_q == WRESP) && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rvalid  = (state_q == RDATA);
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign dbg_state_o   = state_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// Randomised bench for axi_scratchpad_slave against a beat-list model of the scratchpad.
module tb_axi_scratchpad_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [1:0]  INCR  = 2'b01;
    localparam logic [1:0]  FIXED = 2'b00;
    localparam logic [1:0]  WRAP  = 2'b10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0, s_axi_rdata;
    logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
    logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
    logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0, s_axi_bresp, s_axi_rresp;
    logic        s_axi_awvalid = 1'b0, s_axi_arvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_wlast = 1'b0;
    logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mdl [DEPTH];
    logic [31:0] wdata_q[$];
    logic [3:0]  wstrb_q[$];
    logic [31:0] exp_q[$];
    logic [1:0]  exp_resp_q[$];

    always #5 clk_i = ~clk_i;

    axi_scratchpad_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0), .s_axi_awregion(4'h0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0), .s_axi_arregion(4'h0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .dbg_state_o(dbg_state)
    );

    // Reference rules: byte address of beat i, and whether that beat may touch the scratchpad.
    function automatic logic [63:0] model_addr(input logic [31:0] start, input int i, input logic [2:0] size, input logic [1:0] burst);
        if (burst == INCR) return 64'(start) + 64'(i) * (64'd1 << size);
        return 64'(start);
    endfunction

    function automatic bit model_ok(input logic [63:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (burst == INCR || burst == FIXED) && (size <= 3'd2) && (a >= 64'(BASE)) && (a < 64'(BASE) + 64'(4 * DEPTH));
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                               input int bad_last, output logic [1:0] resp);
        logic [63:0] a;
        int idx;
        resp = 2'b00;
        for (int i = 0; i <= len; i++) begin
            a = model_addr(addr, i, size, burst);
            if (model_ok(a, size, burst)) begin
                idx = int'((a - 64'(BASE)) >> 2);
                for (int b = 0; b < 4; b++) if (wstrb_q[i][b]) mdl[idx][8*b +: 8] = wdata_q[i][8*b +: 8];
            end else begin
                resp = 2'b10;
            end
            if (i == bad_last) resp = 2'b10;
        end
    endtask

    task automatic send_aw(input logic [1:0] id, input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst);
        int cyc;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        #1;
        for (cyc = 0; cyc < 50 && s_axi_awready !== 1'b1; cyc++) begin @(negedge clk_i); #1; end
        n_vec++;
        if (s_axi_awready !== 1'b1) begin n_err++; $display("FAIL aw_handshake: awready=%b after %0d cycles, want 1", s_axi_awready, cyc); end
        @(negedge clk_i);
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [1:0] id, input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst);
        int cyc;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        #1;
        for (cyc = 0; cyc < 50 && s_axi_arready !== 1'b1; cyc++) begin @(negedge clk_i); #1; end
        n_vec++;
        if (s_axi_arready !== 1'b1) begin n_err++; $display("FAIL ar_handshake: arready=%b after %0d cycles, want 1", s_axi_arready, cyc); end
        @(negedge clk_i);
        s_axi_arvalid = 1'b0;
    endtask

    task automatic send_w(input int len, input int bad_last, input bit gaps);
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; @(negedge clk_i); end
            s_axi_wvalid = 1'b1; s_axi_wdata = wdata_q[i]; s_axi_wstrb = wstrb_q[i];
            s_axi_wlast = (i == len) ^ (i == bad_last);
            n_vec++;
            if (s_axi_wready !== 1'b1) begin n_err++; $display("FAIL wready beat %0d: got %b want 1", i, s_axi_wready); end
            @(negedge clk_i);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic recv_b(input logic [1:0] id, input logic [1:0] resp);
        int cyc;
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        s_axi_bready = 1'b1;
        for (cyc = 0; cyc < 50 && s_axi_bvalid !== 1'b1; cyc++) @(negedge clk_i);
        n_vec++;
        if ({s_axi_bvalid, s_axi_bid, s_axi_bresp} !== {1'b1, id, resp}) begin
            n_err++;
            $display("FAIL bresp: got valid=%b id=%0d resp=%0d, want valid=1 id=%0d resp=%0d", s_axi_bvalid, s_axi_bid, s_axi_bresp, id, resp);
        end
        @(negedge clk_i);
        s_axi_bready = 1'b0;
        n_vec++;
        if (s_axi_bvalid !== 1'b0) begin n_err++; $display("FAIL bvalid_drop: got %b want 0", s_axi_bvalid); end
    endtask

    // Called on the first falling edge after the AR handshake, i.e. the cycle beat 0 must already be valid.
    task automatic recv_r(input logic [1:0] id, input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input bit stalls);
        logic [63:0] a;
        logic [31:0] e;
        logic [1:0]  er;
        logic [37:0] got, want;
        for (int i = 0; i <= len; i++) begin
            a = model_addr(addr, i, size, burst);
            if (model_ok(a, size, burst)) begin
                exp_q.push_back(mdl[int'((a - 64'(BASE)) >> 2)]); exp_resp_q.push_back(2'b00);
            end else begin
                exp_q.push_back(32'h0); exp_resp_q.push_back(2'b10);
            end
        end
        for (int i = 0; i <= len; i++) begin
            e = exp_q.pop_front(); er = exp_resp_q.pop_front();
            want = {1'b1, id, e, er, (i == len)};
            repeat (stalls ? $urandom_range(0, 2) : 0) begin
                s_axi_rready = 1'b0;
                got = {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
                n_vec++;
                if (got !== want) begin n_err++; $display("FAIL r_hold beat %0d: got %h want %h", i, got, want); end
                @(negedge clk_i);
            end
            s_axi_rready = 1'b1;
            got = {s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
            n_vec++;
            if (got !== want) begin n_err++; $display("FAIL r_beat %0d {valid,id,data,resp,last}: got %h want %h", i, got, want); end
            @(negedge clk_i);
        end
        s_axi_rready = 1'b0;
        n_vec++;
        if (s_axi_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_drop: got %b want 0", s_axi_rvalid); end
    endtask

    task automatic do_write(input logic [1:0] id, input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int bad_last, input bit gaps);
        logic [1:0] resp;
        model_write(addr, len, size, burst, bad_last, resp);
        send_aw(id, addr, len, size, burst);
        send_w(len, bad_last, gaps);
        recv_b(id, resp);
    endtask

    task automatic do_read(input logic [1:0] id, input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stalls);
        send_ar(id, addr, len, size, burst);
        recv_r(id, addr, len, size, burst, stalls);
    endtask

    task automatic check_idle_outputs(input string tag);
        logic [45:0] got;
        got = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_bid, s_axi_bresp,
               s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
        n_vec++;
        if (got !== 46'h0) begin n_err++; $display("FAIL %s: outputs got %h want 0", tag, got); end
    endtask

    task automatic fill_w(input int len, input bit rnd_strb);
        wdata_q.delete(); wstrb_q.delete();
        for (int i = 0; i <= len; i++) begin
            wdata_q.push_back($urandom);
            wstrb_q.push_back(rnd_strb ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        repeat (2) begin @(negedge clk_i); #1; check_idle_outputs("reset_outputs"); end
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_fill();
        fill_w(DEPTH - 1, 1'b0);
        do_write(2'd0, BASE, DEPTH - 1, 3'd2, INCR, -1, 1'b0);
    endtask

    task automatic test_single();
        wdata_q = '{32'hDEAD_BEEF}; wstrb_q = '{4'hF};
        do_write(2'd1, BASE + 32'h10, 0, 3'd2, INCR, -1, 1'b0);
        do_read(2'd2, BASE + 32'h10, 0, 3'd2, INCR, 1'b0);
    endtask

    task automatic test_incr_burst();
        wdata_q.delete(); wstrb_q.delete();
        for (int i = 0; i < 8; i++) begin wdata_q.push_back(32'(i) * 32'h1111_1111); wstrb_q.push_back(4'hF); end
        do_write(2'd3, BASE, 7, 3'd2, INCR, -1, 1'b0);
        do_read(2'd1, BASE, 7, 3'd2, INCR, 1'b0);
    endtask

    task automatic test_strobe();
        wdata_q = '{32'hAABB_CCDD}; wstrb_q = '{4'hF};
        do_write(2'd0, BASE + 32'h20, 0, 3'd2, INCR, -1, 1'b0);
        wdata_q = '{32'h1122_3344}; wstrb_q = '{4'b0101};
        do_write(2'd0, BASE + 32'h20, 0, 3'd2, INCR, -1, 1'b0);
        do_read(2'd3, BASE + 32'h20, 0, 3'd2, INCR, 1'b0);
        n_vec++;
        if (mdl[8] !== 32'hAA22_CC44) begin n_err++; $display("FAIL strobe_model: got %h want aa22cc44", mdl[8]); end
    endtask

    task automatic test_arbitration();
        logic [1:0] resp;
        rst_ni = 1'b0; @(negedge clk_i); rst_ni = 1'b1;
        fill_w(1, 1'b0);
        model_write(BASE + 32'h30, 1, 3'd2, INCR, -1, resp);
        s_axi_awid = 2'd0; s_axi_awaddr = BASE + 32'h30; s_axi_awlen = 8'd1; s_axi_awsize = 3'd2; s_axi_awburst = INCR;
        s_axi_arid = 2'd3; s_axi_araddr = BASE + 32'h30; s_axi_arlen = 8'd1; s_axi_arsize = 3'd2; s_axi_arburst = INCR;
        s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1;
        #1; n_vec++;
        if ({s_axi_awready, s_axi_arready} !== 2'b10) begin n_err++; $display("FAIL arb_first: {awready,arready} got %b want 10", {s_axi_awready, s_axi_arready}); end
        @(negedge clk_i); s_axi_awvalid = 1'b0;
        #1; n_vec++;
        if (s_axi_arready !== 1'b0) begin n_err++; $display("FAIL arb_busy: arready got %b want 0", s_axi_arready); end
        send_w(1, -1, 1'b0);
        recv_b(2'd0, resp);
        s_axi_awid = 2'd2; s_axi_awaddr = BASE + 32'h38; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        #1; n_vec++;
        if ({s_axi_awready, s_axi_arready} !== 2'b01) begin n_err++; $display("FAIL arb_second: {awready,arready} got %b want 01", {s_axi_awready, s_axi_arready}); end
        @(negedge clk_i); s_axi_arvalid = 1'b0;
        recv_r(2'd3, BASE + 32'h30, 1, 3'd2, INCR, 1'b1);
        s_axi_arid = 2'd1; s_axi_araddr = BASE + 32'h38; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        #1; n_vec++;
        if ({s_axi_awready, s_axi_arready} !== 2'b10) begin n_err++; $display("FAIL arb_third: {awready,arready} got %b want 10", {s_axi_awready, s_axi_arready}); end
        fill_w(0, 1'b0);
        model_write(BASE + 32'h38, 0, 3'd2, INCR, -1, resp);
        @(negedge clk_i); s_axi_awvalid = 1'b0;
        send_w(0, -1, 1'b0);
        recv_b(2'd2, resp);
        #1; n_vec++;
        if ({s_axi_awready, s_axi_arready} !== 2'b01) begin n_err++; $display("FAIL arb_fourth: {awready,arready} got %b want 01", {s_axi_awready, s_axi_arready}); end
        @(negedge clk_i); s_axi_arvalid = 1'b0;
        recv_r(2'd1, BASE + 32'h38, 0, 3'd2, INCR, 1'b0);
    endtask

    task automatic test_boundary();
        do_read(2'd2, BASE + 32'(4 * DEPTH) - 32'd4, 1, 3'd2, INCR, 1'b0);
        do_read(2'd1, BASE - 32'd8, 3, 3'd2, INCR, 1'b0);
        fill_w(3, 1'b0);
        do_write(2'd1, BASE + 32'h40, 3, 3'd2, WRAP, -1, 1'b0);
        do_read(2'd1, BASE + 32'h40, 3, 3'd2, INCR, 1'b0);
        do_read(2'd0, BASE + 32'h40, 1, 3'd2, WRAP, 1'b0);
        do_read(2'd0, BASE, 0, 3'd3, INCR, 1'b0);
        fill_w(2, 1'b0);
        do_write(2'd3, BASE + 32'h50, 2, 3'd2, INCR, 1, 1'b0);
        do_write(2'd3, BASE + 32'h50, 2, 3'd2, INCR, 2, 1'b0);
        do_read(2'd3, BASE + 32'h50, 2, 3'd2, FIXED, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] resp;
        fill_w(7, 1'b0);
        model_write(BASE + 32'h80, 2, 3'd2, INCR, -1, resp);
        send_aw(2'd2, BASE + 32'h80, 7, 3'd2, INCR);
        send_w(2, -1, 1'b0);
        s_axi_wvalid = 1'b1; s_axi_wdata = wdata_q[3]; s_axi_wstrb = 4'hF;
        rst_ni = 1'b0;
        @(negedge clk_i);
        s_axi_wvalid = 1'b0;
        #1; check_idle_outputs("reset_mid_burst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_read(2'd0, BASE + 32'h80, 7, 3'd2, INCR, 1'b1);
        fill_w(1, 1'b1);
        do_write(2'd1, BASE + 32'h84, 1, 3'd2, INCR, -1, 1'b1);
        do_read(2'd1, BASE + 32'h80, 3, 3'd2, INCR, 1'b0);
    endtask

    task automatic test_random();
        int r, len, bad;
        logic [2:0] size;
        logic [1:0] burst;
        logic [31:0] addr;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            burst = (r < 6) ? INCR : (r < 8) ? FIXED : (r == 8) ? WRAP : 2'b11;
            size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
            len = $urandom_range(0, 15);
            addr = BASE - 32'd32 + 32'(4 * $urandom_range(0, DEPTH + 16));
            if ($urandom_range(0, 1) == 0) begin
                fill_w(len, 1'b1);
                bad = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
                do_write(2'($urandom), addr, len, size, burst, bad, 1'b1);
            end else begin
                do_read(2'($urandom), addr, len, size, burst, 1'b1);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_single();
        test_incr_burst();
        test_strobe();
        test_arbitration();
        test_boundary();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
